spi_s_rx: RTL and testbench
===========================

// Module: spi_s_rx
// PURPOSE
//  SPI receive stage fed by the team's SPI master (cs/sclk/mosi, LSB first, 12-bit frames).
//  Oversamples the SPI pins in the system clk domain, shifts in one frame per cs-low window,
//  and presents the word on dout with a one-cycle done strobe to the downstream consumer.
//  The master toggles mosi on sclk rising edges, so this block samples on sclk falling edges.
// PARAMETERS
//  DATA_W   12  payload bits per frame
//  LEAD     1   leading dummy falling edges per frame (master: cs drops one sclk before bit0)
// PORTS
//  clk    in   1       system clock (same clk that drives the master's sclk divider)
//  rst    in   1       asynchronous, active-low reset
//  cs     in   1       chip select from master, active low, async to clk
//  sclk   in   1       SPI clock from master, async to clk
//  mosi   in   1       serial data from master
//  dout   out  DATA_W  last received word, held until the next good frame
//  done   out  1       1-cycle pulse, dout updated in the same cycle
//  busy   out  1       high while the FSM is in RECV
//  ferr   out  1       1-cycle frame-error pulse (only with SPI_S_RX_FERR_EN)
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; dout=0, done=0, busy=0, ferr=0; shreg=0, bitcnt=0; sync flops=idle level (cs=1, sclk=0, mosi=0).
//  Sync: cs/sclk/mosi each pass through 2 flops; a third flop holds the previous value for edge detect.
//   sclk_fall = ~sclk_s & sclk_d; cs_fall/cs_rise are defined the same way.
//  FSM states: IDLE, RECV.
//   IDLE: busy=0. On cs_fall -> RECV; clear bitcnt and shreg.
//   RECV: busy=1. On each sclk_fall: shreg <= {mosi_s, shreg[DATA_W-1:1]} (LSB first, new bit enters the MSB).
//         bitcnt++ saturates at 2^CW-1, where CW=$clog2(DATA_W+LEAD+2).
//    On cs_rise -> IDLE; in the same edge, dout <= shreg_next and done <= 1.
//    shreg_next includes a sclk_fall that coincides with the cs_rise.
//  A full frame gives DATA_W+LEAD falling edges; the LEAD dummy samples are shifted out of the low end.
//  Latency: done asserts on the 3rd clk rising edge after the cs pin rises (+1 cycle for pin/edge alignment).
//  done/ferr are exactly 1 cycle; dout is stable except in the done cycle.
//  sclk toggling while cs is high is ignored; no shifting happens in IDLE.
//  cs_fall while in RECV is impossible after sync and is ignored.
//  Reset mid-frame aborts the frame: no done, dout returns to 0, and the next cs_fall starts clean.
//  Short or long frames (bitcnt != DATA_W+LEAD): behaviour depends on the configuration below.
// CONFIGURATION
//  SPI_S_RX_FERR_EN defined:
//   - ferr port exists.
//   - On cs_rise with bitcnt != DATA_W+LEAD: ferr pulses 1 cycle, done stays 0, dout is unchanged.
//  SPI_S_RX_FERR_EN undefined:
//   - no ferr port and no length check.
//   - Every cs_rise in RECV pulses done with dout <= shreg_next, even for short or long frames.
// STRUCTURE
//  Package spi_pkg:
//   - typedef enum logic {RX_IDLE, RX_RECV} spi_rx_state_t
//   - localparam SPI_DATA_W=12, SPI_LEAD=1
//  Sub-module spi_sync2:
//   - 2-flop synchronizer plus prev flop; outputs lvl, rise, fall.
//   - Async active-low reset; reset value set by parameter INIT.
//   - Instantiated 3x (cs, sclk, mosi).
// TESTING (bench drives this block from the master, sclk = clk/22)
//  1 din=12'hA5C, newd pulse -> exactly one done pulse, dout=12'hA5C, busy low afterwards.
//  2 Back-to-back frames 12'h001 then 12'h800 -> two done pulses, in order: dout=12'h001, then 12'h800.
//  3 rst=0 for 2 clk mid-frame (after 5 bits), then a frame 12'h3C3 -> no done for the aborted frame; dout=0 until the 12'h3C3 done.
//  4 Bench-driven pins: sclk toggling with cs=1 for 40 clk -> done=0, busy=0, dout unchanged.
//  5 [FERR_EN] Bench frame with cs low for only 6 falling edges -> ferr pulse, done=0, dout keeps its prior value.
//    [!FERR_EN] Same frame -> done pulse.
//  6 Frame 12'hFFF then 12'h000 -> dout=12'hFFF, then dout=12'h000 (checks that the dummy lead bit never leaks into bit0).

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared types and frame constants for the SPI receive slice
package spi_pkg;
    typedef enum logic {RX_IDLE, RX_RECV} spi_rx_state_t;
    localparam int SPI_DATA_W = 12;
    localparam int SPI_LEAD   = 1;
endpackage

// File: rtl/spi_sync2.sv
// spi_sync2: two-flop synchronizer with a history flop for edge detection
module spi_sync2 #(
    parameter logic INIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic lvl,
    output logic rise,
    output logic fall
);
    logic s1_q, s1_d, s2_q, s2_d, p_q, p_d;
    // next values simply march the pin through the chain
    always_comb begin
        s1_d = din;
        s2_d = s1_q;
        p_d  = s2_q;
    end
    // chain registers, reset to the pin's idle level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= INIT;
            s2_q <= INIT;
            p_q  <= INIT;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            p_q  <= p_d;
        end
    end
    assign lvl  = s2_q;
    assign rise = s2_q & ~p_q;
    assign fall = ~s2_q & p_q;
endmodule

// File: rtl/spi_s_rx.sv
// spi_s_rx: oversampled SPI slave receiver, LSB first; SPI_S_RX_FERR_EN adds length check and ferr
module spi_s_rx
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W,
    parameter int LEAD   = SPI_LEAD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              sclk,
    input  logic              mosi,
    output logic [DATA_W-1:0] dout,
    output logic              done,
`ifdef SPI_S_RX_FERR_EN
    output logic              ferr,
`endif
    output logic              busy
);
    localparam int CW = $clog2(DATA_W + LEAD + 2);

    logic cs_fall, cs_rise, sclk_fall, mosi_s;
    logic unused_cs_lvl, unused_sclk_lvl, unused_sclk_rise, unused_mosi_rise, unused_mosi_fall;

    spi_sync2 #(.INIT(1'b1)) u_cs (
        .clk(clk), .rst(rst), .din(cs),
        .lvl(unused_cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );
    spi_sync2 #(.INIT(1'b0)) u_sclk (
        .clk(clk), .rst(rst), .din(sclk),
        .lvl(unused_sclk_lvl), .rise(unused_sclk_rise), .fall(sclk_fall)
    );
    spi_sync2 #(.INIT(1'b0)) u_mosi (
        .clk(clk), .rst(rst), .din(mosi),
        .lvl(mosi_s), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
    );

    spi_rx_state_t state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d, dout_q, dout_d, shreg_nx;
    logic [CW-1:0] bitcnt_q, bitcnt_d, bitcnt_nx;
    logic done_q, done_d, ferr_q, ferr_d, len_ok;

    // next state, shifting and frame completion; a fall coinciding with cs_rise still counts
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        dout_d    = dout_q;
        done_d    = 1'b0;
        ferr_d    = 1'b0;
        shreg_nx  = sclk_fall ? {mosi_s, shreg_q[DATA_W-1:1]} : shreg_q;
        bitcnt_nx = (sclk_fall && bitcnt_q != '1) ? bitcnt_q + 1'b1 : bitcnt_q;
`ifdef SPI_S_RX_FERR_EN
        len_ok    = bitcnt_nx == CW'(DATA_W + LEAD);
`else
        len_ok    = 1'b1;
`endif
        if (state_q == RX_IDLE) begin
            if (cs_fall) begin
                state_d  = RX_RECV;
                bitcnt_d = '0;
                shreg_d  = '0;
            end
        end else begin
            shreg_d  = shreg_nx;
            bitcnt_d = bitcnt_nx;
            if (cs_rise) begin
                state_d = RX_IDLE;
                dout_d  = len_ok ? shreg_nx : dout_q;
                done_d  = len_ok;
                ferr_d  = !len_ok;
            end
        end
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= RX_IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            dout_q   <= '0;
            done_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            dout_q   <= dout_d;
            done_q   <= done_d;
            ferr_q   <= ferr_d;
        end
    end

    assign dout = dout_q;
    assign done = done_q;
    assign busy = state_q == RX_RECV;
`ifdef SPI_S_RX_FERR_EN
    assign ferr = ferr_q;
`else
    logic unused_ferr;
    assign unused_ferr = ferr_q;
`endif
endmodule

// File: tb/tb_spi_s_rx.sv
// tb_spi_s_rx: directed bench for spi_s_rx, modelling the master's pin timing (sclk = clk/22)
module tb_spi_s_rx;
    logic clk = 1'b0, rst = 1'b0, cs = 1'b1, sclk = 1'b0, mosi = 1'b0;
    logic [11:0] dout;
    logic done, busy;
`ifdef SPI_S_RX_FERR_EN
    logic ferr;
`endif
    int n_chk = 0, n_pass = 0, n_done = 0, n_ferr = 0;
    logic [11:0] got[$];

    spi_s_rx dut (
        .clk(clk), .rst(rst), .cs(cs), .sclk(sclk), .mosi(mosi),
        .dout(dout), .done(done),
`ifdef SPI_S_RX_FERR_EN
        .ferr(ferr),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    // record every done pulse and the word it presents
    always @(negedge clk) begin
        if (done) begin
            n_done++;
            got.push_back(dout);
        end
`ifdef SPI_S_RX_FERR_EN
        if (ferr) n_ferr++;
`endif
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // n sclk periods with cs low; bits[i] is driven on the i-th rising edge
    task automatic frame(input logic [15:0] bits, input int n);
        cs = 1'b0;
        tick(11);
        for (int i = 0; i < n; i++) begin
            sclk = 1'b1;
            mosi = bits[i];
            tick(11);
            sclk = 1'b0;
            tick(11);
        end
        cs = 1'b1;
        tick(22);
    endtask

    task automatic word(input logic [11:0] w);
        frame({3'b000, w, 1'b0}, 13);
    endtask

    task automatic pop(input string tag, input logic [11:0] exp);
        if (got.size() == 0) chk({tag, "_missing"}, 32'd0, 32'd1);
        else chk(tag, got.pop_front(), exp);
    endtask

    initial begin
        int d0;
        tick(3);
        chk("rst_dout", dout, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;
        tick(5);

        word(12'hA5C);
        chk("t1_ndone", n_done, 1);
        pop("t1_dout", 12'hA5C);
        chk("t1_busy", busy, 0);
        chk("t1_hold", dout, 12'hA5C);

        word(12'h001);
        word(12'h800);
        chk("t2_ndone", n_done, 3);
        pop("t2_first", 12'h001);
        pop("t2_second", 12'h800);

        cs = 1'b0;
        tick(11);
        for (int i = 0; i < 6; i++) begin
            sclk = 1'b1;
            mosi = i[0];
            tick(11);
            sclk = 1'b0;
            tick(11);
        end
        chk("t3_busy_mid", busy, 1);
        rst = 1'b0;
        cs = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(10);
        chk("t3_ndone_abort", n_done, 3);
        chk("t3_dout_zero", dout, 0);
        chk("t3_busy", busy, 0);
        word(12'h3C3);
        chk("t3_ndone", n_done, 4);
        pop("t3_dout", 12'h3C3);

        for (int i = 0; i < 20; i++) begin
            sclk = ~sclk;
            mosi = 1'($urandom);
            tick(2);
        end
        sclk = 1'b0;
        tick(5);
        chk("t4_ndone", n_done, 4);
        chk("t4_busy", busy, 0);
        chk("t4_dout", dout, 12'h3C3);

        d0 = n_done;
        frame(16'h003F, 6);
`ifdef SPI_S_RX_FERR_EN
        chk("t5_ferr", n_ferr, 1);
        chk("t5_ndone", n_done, d0);
        chk("t5_dout", dout, 12'h3C3);
`else
        chk("t5_ndone", n_done, d0 + 1);
        pop("t5_dout", 12'hFC0);
`endif

        word(12'hFFF);
        pop("t6_fff", 12'hFFF);
        word(12'h000);
        pop("t6_000", 12'h000);
        chk("t6_busy", busy, 0);
        chk("t6_extra", got.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
